// File: rtl/contestant_input_conditioner_pkg.sv
// Shared definitions for the contestant front end, arbiter and display stages.
//   - round_state_t : encoding of the host-controlled round state
//   - N_CH          : number of contestant channels in the system
//   - DEBOUNCE_CYCLES_DEFAULT / CNT_W_DEFAULT : 20 ms at 50 MHz
//   - round_open()  : true while presses may reach the arbiter
package contestant_input_conditioner_pkg;

  localparam int N_CH                    = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT           = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_LOCKED = 2'b10
  } round_state_t;

  function automatic logic round_open(input round_state_t s);
    return (s == ST_ARMED) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/contestant_input_conditioner_debounce_channel.sv
// One contestant channel: polarity correction, two-flop synchroniser,
// debounce counter, stable level and press-edge detection.
// Ports:
//   clock, reset (async, active low)
//   btn_raw    : raw pushbutton, asynchronous to clock
//   stable     : debounced "pressed" level
//   press_edge : combinational, high in the cycle after stable rose
module contestant_input_conditioner_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic press_edge
);

  logic             pressed_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Normalise so that 1 always means "pressed" before synchronising.
  assign pressed_s = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Synchroniser, debounce counter and stable level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      sync1_r    <= pressed_s;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      if (sync2_r != stable_r) begin
        // The level changes only after DEBOUNCE_CYCLES disagreeing cycles in a row.
        if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_r <= sync2_r;
          cnt_r    <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign stable     = stable_r;
  // stable_d_r lags by one cycle, so this is high in the cycle after a rise.
  assign press_edge = stable_r & ~stable_d_r;

endmodule

// File: rtl/contestant_input_conditioner.sv
// Contestant input conditioner: debounced buttons, round FSM, false-start
// flags, first-presser capture and gated contestant levels for the arbiter.
// Ports:
//   clock, reset (async, active low)
//   btn_raw[N_CH]     : raw pushbuttons
//   arm, clear        : single-cycle host pulses (clear has priority)
//   con_out[N_CH]     : stable level gated by round state and foul
//   press_pulse[N_CH] : one-cycle pulse per debounced press, ungated
//   winner[N_CH]      : one-hot first valid presser, held until clear
//   foul[N_CH]        : sticky false-start flags
//   round_state[2]    : 00 IDLE, 01 ARMED, 10 LOCKED
module contestant_input_conditioner #(
  parameter int N_CH            = contestant_input_conditioner_pkg::N_CH,
  parameter int DEBOUNCE_CYCLES = contestant_input_conditioner_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = contestant_input_conditioner_pkg::CNT_W_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  input  logic            arm,
  input  logic            clear,
  output logic [N_CH-1:0] con_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] winner,
  output logic [N_CH-1:0] foul,
  output logic [1:0]      round_state
);

  import contestant_input_conditioner_pkg::*;

  logic [N_CH-1:0] stable_s;
  logic [N_CH-1:0] press_edge_s;
  logic [N_CH-1:0] valid_s;
  logic [N_CH-1:0] winner_nxt_s;
  logic [N_CH-1:0] foul_nxt_s;
  round_state_t    state_nxt_s;

  round_state_t    state_r;
  logic [N_CH-1:0] winner_r;
  logic [N_CH-1:0] foul_r;
  logic [N_CH-1:0] press_pulse_r;
  logic [N_CH-1:0] con_out_r;

  // Isolate the lowest set bit: ties go to the lowest channel index.
  function automatic logic [N_CH-1:0] lowest_one(input logic [N_CH-1:0] v);
    return v & (~v + N_CH'(1));
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    contestant_input_conditioner_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .stable     (stable_s[i]),
      .press_edge (press_edge_s[i])
    );
  end

  // Round FSM next state, foul flags and winner capture.
  always_comb begin
    state_nxt_s  = state_r;
    winner_nxt_s = winner_r;
    foul_nxt_s   = foul_r;
    valid_s      = press_edge_s & ~foul_r;
    if (clear) begin
      state_nxt_s  = ST_IDLE;
      winner_nxt_s = {N_CH{1'b0}};
      foul_nxt_s   = {N_CH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A press before arming is a false start, even on the arming edge.
          foul_nxt_s = foul_r | press_edge_s;
          if (arm) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (valid_s != {N_CH{1'b0}}) begin
            state_nxt_s  = ST_LOCKED;
            winner_nxt_s = lowest_one(valid_s);
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_LOCKED: begin
          state_nxt_s = ST_LOCKED;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Round state, flags and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      winner_r      <= {N_CH{1'b0}};
      foul_r        <= {N_CH{1'b0}};
      press_pulse_r <= {N_CH{1'b0}};
      con_out_r     <= {N_CH{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      winner_r      <= winner_nxt_s;
      foul_r        <= foul_nxt_s;
      press_pulse_r <= press_edge_s;
      con_out_r     <= stable_s & {N_CH{round_open(state_r)}} & ~foul_r;
    end
  end

  assign con_out     = con_out_r;
  assign press_pulse = press_pulse_r;
  assign winner      = winner_r;
  assign foul        = foul_r;
  assign round_state = state_r;

endmodule

// File: doc/contestant_input_conditioner.md
Name: contestant_input_conditioner

Overview:
- Front-end stage feeding the quiz-buzzer arbiter's con0..con2 inputs.
- Synchronises and debounces the raw contestant pushbuttons and produces clean press pulses.
- Gates each contestant with a host-controlled round state machine (IDLE/ARMED/LOCKED).
- Flags false starts: presses made before the round is armed.

Parameters:
- N_CH, 3, number of contestant channels.
- DEBOUNCE_CYCLES, 1000000, consecutive clock cycles a synchronised input must disagree with the stable level before the level changes (20 ms at 50 MHz); minimum 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 means a raw 0 is "pressed"; the raw input is inverted before synchronisation.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  N_CH  raw pushbuttons, asynchronous to clock.
- arm  in  1  single-cycle synchronous pulse from host: open the round.
- clear  in  1  single-cycle synchronous pulse from host: end the round and clear fouls.
- con_out  out  N_CH  per-channel pressed level, gated (drives arbiter con inputs).
- press_pulse  out  N_CH  one-cycle pulse on each debounced press, ungated.
- winner  out  N_CH  one-hot first valid presser of the round, held until clear.
- foul  out  N_CH  sticky false-start flag per channel.
- round_state  out  2  00 IDLE, 01 ARMED, 10 LOCKED.

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, stable levels, counters, press_pulse, winner, foul and con_out go to 0; round_state goes to IDLE.
- Every flop is cleared by reset, including mid-debounce; the first post-reset stable level is "released".

Synchroniser:
- Two-flop synchroniser per channel, applied after polarity correction.

Debounce, per channel:
- Counter increments on every cycle where sync != stable; cleared on any cycle where sync == stable.
- When the counter equals DEBOUNCE_CYCLES-1 and still disagrees: stable <= sync, counter <= 0.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.

Press edge and latency:
- press_pulse[i] is registered and high for exactly one cycle on the cycle after stable[i] rises.
- Latency: the raw change is captured at edge 0; stable flips at edge DEBOUNCE_CYCLES+1; press_pulse rises at edge DEBOUNCE_CYCLES+2.
- Release produces no pulse.

Round FSM (transitions evaluated on the same edge press_pulse is registered; uses the press-edge condition):
- IDLE: arm -> ARMED. A press edge on channel i sets foul[i].
- ARMED: a press edge on any channel with foul[i]=0 -> LOCKED, and winner captures that channel. Press edges from fouled channels are ignored.
- LOCKED: all presses are ignored; arm is ignored.
- clear in any state -> IDLE; foul and winner cleared.
- clear and arm in the same cycle: clear wins.
- arm while ARMED or LOCKED: ignored.

Simultaneous events:
- Multiple valid press edges in the same cycle while ARMED: lowest index wins; winner stays one-hot.
- A press edge in IDLE coincident with arm: foul is set and the state still goes to ARMED.

Gating:
- con_out[i] = stable[i] AND (round_state==ARMED or LOCKED) AND NOT foul[i]. Registered; one cycle behind stable.
- con_out drops to 0 on the cycle after clear.

Decomposition:
- Shared package holds:
  - round-state encodings (ST_IDLE=2'b00, ST_ARMED=2'b01, ST_LOCKED=2'b10);
  - default DEBOUNCE_CYCLES;
  - N_CH=3 constant, shared with the arbiter and display stages.
- One sub-module, debounce_channel:
  - contents: polarity correction, 2-flop synchroniser, counter, stable level, press-edge output;
  - instantiated N_CH times.
- FSM, winner priority encoder and gating live in the top.

Test Plan (DEBOUNCE_CYCLES=4, active-low buttons):
- Reset: hold reset=0 with btn_raw=3'b000 (all pressed) -> all outputs 0, round_state=00. Release reset -> press_pulse=3'b111 at edge 6, foul=3'b111, state stays IDLE.
- Glitch rejection: btn_raw[1] low for 3 cycles, then high -> no press_pulse, stable unchanged. Low for 6 cycles -> press_pulse[1] one cycle at edge 6.
- Normal round: arm; btn_raw[2] pressed -> at edge 6, press_pulse=3'b100, winner=3'b100, state=10, con_out=3'b100 next cycle. Later press on ch0 -> press_pulse[0] only; winner unchanged.
- False start: press ch0 while IDLE -> foul=3'b001; arm; ch0 and ch1 pressed together -> winner=3'b010, con_out[0]=0.
- Tie: arm; ch0 and ch2 pressed on the same cycle -> winner=3'b001.
- Clear priority: assert arm and clear together in LOCKED -> next state IDLE, winner=0, foul=0, con_out=0.
